// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: forward-select codes,
// FSM encodings and the layout of one shadow-pipe stage record.
package hazard_ctrl_pkg;

  localparam int SH_RW_W = 5;

  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  typedef enum logic {
    RUN    = 1'b0,
    MCWAIT = 1'b1
  } state_e;

  typedef struct packed {
    logic [SH_RW_W-1:0] rw;
    logic               regwrite;
    logic               mem2reg;
  } shadow_t;

  localparam shadow_t SHADOW_BUBBLE = '{rw: '0, regwrite: 1'b0, mem2reg: 1'b0};

  // The nearer producer always wins when both candidate stages match.
  function automatic logic [1:0] fwd_pick(input logic near_hit, input logic far_hit);
    if (near_hit)     return FWD_EXMEM;
    else if (far_hit) return FWD_MEMWB;
    else              return FWD_REG;
  endfunction

endpackage

// File: rtl/hazard_ctrl_match.sv
// Single source-vs-producer comparator; register 0 is hard-wired and never
// creates a dependency.
module hazard_ctrl_match
  import hazard_ctrl_pkg::*;
#(
  parameter int RW_W = SH_RW_W
) (
  input  logic [RW_W-1:0] rs,
  input  logic            use_rs,
  input  logic [RW_W-1:0] rw,
  input  logic            regwrite,
  output logic            hit
);

  assign hit = use_rs & regwrite & (rs == rw) & (rs != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/forwarding sequencer for the 5-stage pipe: tracks in-flight destinations,
// stalls IF/ID on load-use, ID-branch and multi-cycle hazards, and issues forward selects.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int RW_W   = SH_RW_W,
  parameter int MC_LAT = 4,
  parameter int CNT_W  = 3
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            id_valid,
  input  logic [RW_W-1:0] id_rs1,
  input  logic [RW_W-1:0] id_rs2,
  input  logic            id_use_rs1,
  input  logic            id_use_rs2,
  input  logic            id_br,
  input  logic [RW_W-1:0] id_rw,
  input  logic            id_regwrite,
  input  logic            id_mem2reg,
  input  logic            id_mc_op,
  output logic            stall_if,
  output logic            stall_id,
  output logic            bubble_ex,
  output logic [1:0]      fwd_a_sel,
  output logic [1:0]      fwd_b_sel,
  output logic [1:0]      id_fwd_a_sel,
  output logic [1:0]      id_fwd_b_sel,
  output logic            mc_busy
);

  localparam logic [CNT_W-1:0] MC_INIT = CNT_W'((MC_LAT > 1) ? MC_LAT - 2 : 0);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  shadow_t           ex_q, ex_d, mem_q, mem_d;
  logic [RW_W-1:0]   wb_rw_q;
  logic              wb_regwrite_q;
  logic [1:0]        fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;

  logic a_ex, a_mem, a_wb, b_ex, b_mem, b_wb;
  logic load_use, br_haz, hazard;

  hazard_ctrl_match #(.RW_W(RW_W)) u_a_ex  (.rs(id_rs1), .use_rs(id_use_rs1), .rw(ex_q.rw),  .regwrite(ex_q.regwrite),  .hit(a_ex));
  hazard_ctrl_match #(.RW_W(RW_W)) u_a_mem (.rs(id_rs1), .use_rs(id_use_rs1), .rw(mem_q.rw), .regwrite(mem_q.regwrite), .hit(a_mem));
  hazard_ctrl_match #(.RW_W(RW_W)) u_a_wb  (.rs(id_rs1), .use_rs(id_use_rs1), .rw(wb_rw_q),  .regwrite(wb_regwrite_q),  .hit(a_wb));
  hazard_ctrl_match #(.RW_W(RW_W)) u_b_ex  (.rs(id_rs2), .use_rs(id_use_rs2), .rw(ex_q.rw),  .regwrite(ex_q.regwrite),  .hit(b_ex));
  hazard_ctrl_match #(.RW_W(RW_W)) u_b_mem (.rs(id_rs2), .use_rs(id_use_rs2), .rw(mem_q.rw), .regwrite(mem_q.regwrite), .hit(b_mem));
  hazard_ctrl_match #(.RW_W(RW_W)) u_b_wb  (.rs(id_rs2), .use_rs(id_use_rs2), .rw(wb_rw_q),  .regwrite(wb_regwrite_q),  .hit(b_wb));

  // A branch resolved in ID cannot take a value from EX, nor a load result still in MEM.
  assign load_use = (a_ex | b_ex) & ex_q.mem2reg;
  assign br_haz   = id_br & ((a_ex | b_ex) | ((a_mem | b_mem) & mem_q.mem2reg));
  assign hazard   = id_valid & (load_use | br_haz);

  assign id_fwd_a_sel = fwd_pick(a_mem & ~mem_q.mem2reg, a_wb);
  assign id_fwd_b_sel = fwd_pick(b_mem & ~mem_q.mem2reg, b_wb);
  assign fwd_a_sel    = fwd_a_q;
  assign fwd_b_sel    = fwd_b_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    bubble_ex = 1'b0;
    mc_busy   = 1'b0;
    ex_d      = SHADOW_BUBBLE;
    mem_d     = ex_q;
    fwd_a_d   = FWD_REG;
    fwd_b_d   = FWD_REG;
    if (id_valid) begin
      ex_d.rw       = id_rw;
      ex_d.regwrite = id_regwrite;
      ex_d.mem2reg  = id_mem2reg;
      fwd_a_d       = fwd_pick(a_ex, a_mem);
      fwd_b_d       = fwd_pick(b_ex, b_mem);
    end
    case (state_q)
      RUN: begin
        if (hazard) begin
          stall_if  = 1'b1;
          stall_id  = 1'b1;
          bubble_ex = 1'b1;
          ex_d      = SHADOW_BUBBLE;
          fwd_a_d   = FWD_REG;
          fwd_b_d   = FWD_REG;
        end else if (id_valid && id_mc_op && (MC_LAT > 1)) begin
          state_d = MCWAIT;
          cnt_d   = MC_INIT;
        end
      end
      MCWAIT: begin
        // The multi-cycle op sits in EX with its selects; nothing new reaches MEM.
        stall_if = 1'b1;
        stall_id = 1'b1;
        mc_busy  = 1'b1;
        ex_d     = ex_q;
        mem_d    = SHADOW_BUBBLE;
        fwd_a_d  = fwd_a_q;
        fwd_b_d  = fwd_b_q;
        if (cnt_q == '0) state_d = RUN;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= RUN;
      cnt_q         <= '0;
      ex_q          <= SHADOW_BUBBLE;
      mem_q         <= SHADOW_BUBBLE;
      wb_rw_q       <= '0;
      wb_regwrite_q <= 1'b0;
      fwd_a_q       <= FWD_REG;
      fwd_b_q       <= FWD_REG;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      ex_q          <= ex_d;
      mem_q         <= mem_d;
      wb_rw_q       <= mem_q.rw;
      wb_regwrite_q <= mem_q.regwrite;
      fwd_a_q       <= fwd_a_d;
      fwd_b_q       <= fwd_b_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl: each task walks one hazard/forwarding
// scenario cycle by cycle against hand-derived expectations.
module tb_hazard_ctrl;

  logic       clock, reset;
  logic       id_valid, id_use_rs1, id_use_rs2, id_br, id_regwrite, id_mem2reg, id_mc_op;
  logic [4:0] id_rs1, id_rs2, id_rw;
  logic       stall_if, stall_id, bubble_ex, mc_busy;
  logic [1:0] fwd_a_sel, fwd_b_sel, id_fwd_a_sel, id_fwd_b_sel;

  int vectors = 0;
  int miscompares = 0;

  // Bundles: {stall_if,stall_id,bubble_ex,mc_busy}, {fwd_a,fwd_b}, {id_fwd_a,id_fwd_b}
  logic [3:0] stl, fwd, idf;
  assign stl = {stall_if, stall_id, bubble_ex, mc_busy};
  assign fwd = {fwd_a_sel, fwd_b_sel};
  assign idf = {id_fwd_a_sel, id_fwd_b_sel};

  hazard_ctrl dut (
    .clock(clock), .reset(reset), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_br(id_br), .id_rw(id_rw), .id_regwrite(id_regwrite), .id_mem2reg(id_mem2reg),
    .id_mc_op(id_mc_op), .stall_if(stall_if), .stall_id(stall_id), .bubble_ex(bubble_ex),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .id_fwd_a_sel(id_fwd_a_sel),
    .id_fwd_b_sel(id_fwd_b_sel), .mc_busy(mc_busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic setId(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2, input logic br, input logic [4:0] rw,
                       input logic rwr, input logic m2r, input logic mc);
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
    id_br = br; id_rw = rw; id_regwrite = rwr; id_mem2reg = m2r; id_mc_op = mc;
  endtask

  task automatic idle();
    setId(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic nextCycle();
    @(posedge clock); #1;
  endtask

  task automatic flush();
    idle();
    repeat (3) nextCycle();
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    repeat (2) nextCycle();
    @(negedge clock);
    vectors++; if ({stl, fwd, idf} !== 12'h000) begin miscompares++; $display("FAIL reset_outputs: got %h want %h", {stl, fwd, idf}, 12'h000); end
    nextCycle();
    reset = 1'b0;
    nextCycle();
  endtask

  // lw r5 ; add r6,r5,r5
  task automatic test_load_use();
    setId(1, 0, 0, 0, 0, 0, 5'd5, 1, 1, 0);
    @(negedge clock);
    vectors++; if (stl !== 4'b0000) begin miscompares++; $display("FAIL lu_lw_nostall: got %b want %b", stl, 4'b0000); end
    nextCycle();
    setId(1, 5'd5, 5'd5, 1, 1, 0, 5'd6, 1, 0, 0);
    @(negedge clock);
    vectors++; if (stl !== 4'b1110) begin miscompares++; $display("FAIL lu_stall: got %b want %b", stl, 4'b1110); end
    nextCycle();
    @(negedge clock);
    vectors++; if (stl !== 4'b0000) begin miscompares++; $display("FAIL lu_release: got %b want %b", stl, 4'b0000); end
    vectors++; if (fwd !== 4'b0000) begin miscompares++; $display("FAIL lu_bubble_fwd: got %b want %b", fwd, 4'b0000); end
    nextCycle();
    idle();
    @(negedge clock);
    vectors++; if (fwd !== 4'b1010) begin miscompares++; $display("FAIL lu_fwd_memwb: got %b want %b", fwd, 4'b1010); end
    flush();
  endtask

  // add r3 ; sub r4,r3,r0
  task automatic test_fwd_exmem();
    setId(1, 0, 0, 0, 0, 0, 5'd3, 1, 0, 0);
    nextCycle();
    setId(1, 5'd3, 5'd0, 1, 1, 0, 5'd4, 1, 0, 0);
    @(negedge clock);
    vectors++; if (stl !== 4'b0000) begin miscompares++; $display("FAIL exmem_nostall: got %b want %b", stl, 4'b0000); end
    nextCycle();
    idle();
    @(negedge clock);
    vectors++; if (fwd !== 4'b0100) begin miscompares++; $display("FAIL exmem_fwd: got %b want %b", fwd, 4'b0100); end
    flush();
  endtask

  // Loads and ALU ops feeding a branch resolved in ID, distances 1 and 2
  task automatic test_load_branch();
    setId(1, 0, 0, 0, 0, 0, 5'd7, 1, 1, 0);
    nextCycle();
    setId(1, 5'd7, 5'd1, 1, 1, 1, 5'd0, 0, 0, 0);
    @(negedge clock);
    vectors++; if (stl !== 4'b1110) begin miscompares++; $display("FAIL lbr_d1_stall1: got %b want %b", stl, 4'b1110); end
    nextCycle();
    @(negedge clock);
    vectors++; if (stl !== 4'b1110) begin miscompares++; $display("FAIL lbr_d1_stall2: got %b want %b", stl, 4'b1110); end
    nextCycle();
    @(negedge clock);
    vectors++; if (stl !== 4'b0000) begin miscompares++; $display("FAIL lbr_d1_release: got %b want %b", stl, 4'b0000); end
    vectors++; if (idf !== 4'b1000) begin miscompares++; $display("FAIL lbr_d1_idfwd: got %b want %b", idf, 4'b1000); end
    flush();
    setId(1, 0, 0, 0, 0, 0, 5'd7, 1, 1, 0);
    nextCycle();
    idle();
    nextCycle();
    setId(1, 5'd1, 5'd7, 1, 1, 1, 5'd0, 0, 0, 0);
    @(negedge clock);
    vectors++; if (stl !== 4'b1110) begin miscompares++; $display("FAIL lbr_d2_stall: got %b want %b", stl, 4'b1110); end
    nextCycle();
    @(negedge clock);
    vectors++; if (stl !== 4'b0000) begin miscompares++; $display("FAIL lbr_d2_release: got %b want %b", stl, 4'b0000); end
    vectors++; if (idf !== 4'b0010) begin miscompares++; $display("FAIL lbr_d2_idfwd: got %b want %b", idf, 4'b0010); end
    flush();
    // add r3 ; beq r3,r0 : one stall, then forward from MEM (non-load)
    setId(1, 0, 0, 0, 0, 0, 5'd3, 1, 0, 0);
    nextCycle();
    setId(1, 5'd3, 5'd0, 1, 1, 1, 5'd0, 0, 0, 0);
    @(negedge clock);
    vectors++; if (stl !== 4'b1110) begin miscompares++; $display("FAIL abr_stall: got %b want %b", stl, 4'b1110); end
    nextCycle();
    @(negedge clock);
    vectors++; if (stl !== 4'b0000) begin miscompares++; $display("FAIL abr_release: got %b want %b", stl, 4'b0000); end
    vectors++; if (idf !== 4'b0100) begin miscompares++; $display("FAIL abr_idfwd: got %b want %b", idf, 4'b0100); end
    flush();
  endtask

  // add r2 ; add r2 ; or r9,r2  then  add r2 ; nop ; or r9,r2
  task automatic test_back_to_back();
    setId(1, 0, 0, 0, 0, 0, 5'd2, 1, 0, 0);
    nextCycle();
    setId(1, 0, 0, 0, 0, 0, 5'd2, 1, 0, 0);
    nextCycle();
    setId(1, 5'd2, 5'd0, 1, 0, 0, 5'd9, 1, 0, 0);
    @(negedge clock);
    vectors++; if (stl !== 4'b0000) begin miscompares++; $display("FAIL b2b_nostall: got %b want %b", stl, 4'b0000); end
    nextCycle();
    idle();
    @(negedge clock);
    vectors++; if (fwd !== 4'b0100) begin miscompares++; $display("FAIL b2b_closest: got %b want %b", fwd, 4'b0100); end
    flush();
    setId(1, 0, 0, 0, 0, 0, 5'd2, 1, 0, 0);
    nextCycle();
    idle();
    nextCycle();
    setId(1, 5'd0, 5'd2, 0, 1, 0, 5'd9, 1, 0, 0);
    nextCycle();
    idle();
    @(negedge clock);
    vectors++; if (fwd !== 4'b0010) begin miscompares++; $display("FAIL b2b_memwb_b: got %b want %b", fwd, 4'b0010); end
    flush();
  endtask

  // lw r0 ; add r1,r0,r0 and a load seen with id_valid=0
  task automatic test_r0_and_valid();
    setId(1, 0, 0, 0, 0, 0, 5'd0, 1, 1, 0);
    nextCycle();
    setId(1, 5'd0, 5'd0, 1, 1, 0, 5'd1, 1, 0, 0);
    @(negedge clock);
    vectors++; if (stl !== 4'b0000) begin miscompares++; $display("FAIL r0_nostall: got %b want %b", stl, 4'b0000); end
    nextCycle();
    idle();
    @(negedge clock);
    vectors++; if (fwd !== 4'b0000) begin miscompares++; $display("FAIL r0_fwd: got %b want %b", fwd, 4'b0000); end
    flush();
    setId(0, 0, 0, 0, 0, 0, 5'd5, 1, 1, 0);
    nextCycle();
    setId(1, 5'd5, 5'd5, 1, 1, 0, 5'd6, 1, 0, 0);
    @(negedge clock);
    vectors++; if (stl !== 4'b0000) begin miscompares++; $display("FAIL invalid_nostall: got %b want %b", stl, 4'b0000); end
    nextCycle();
    idle();
    @(negedge clock);
    vectors++; if (fwd !== 4'b0000) begin miscompares++; $display("FAIL invalid_fwd: got %b want %b", fwd, 4'b0000); end
    flush();
  endtask

  // Multi-cycle op (MC_LAT=4): three MCWAIT cycles, dependent op forwarded afterwards
  task automatic test_multicycle();
    setId(1, 0, 0, 0, 0, 0, 5'd8, 1, 0, 1);
    @(negedge clock);
    vectors++; if (stl !== 4'b0000) begin miscompares++; $display("FAIL mc_entry: got %b want %b", stl, 4'b0000); end
    nextCycle();
    setId(1, 5'd8, 5'd0, 1, 0, 0, 5'd10, 1, 0, 0);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clock);
      vectors++; if (stl !== 4'b1101) begin miscompares++; $display("FAIL mc_wait_c%0d: got %b want %b", c, stl, 4'b1101); end
      nextCycle();
    end
    @(negedge clock);
    vectors++; if (stl !== 4'b0000) begin miscompares++; $display("FAIL mc_exit: got %b want %b", stl, 4'b0000); end
    nextCycle();
    idle();
    @(negedge clock);
    vectors++; if (fwd !== 4'b0100) begin miscompares++; $display("FAIL mc_dep_fwd: got %b want %b", fwd, 4'b0100); end
    flush();
  endtask

  // Reset asserted during MCWAIT drops everything immediately
  task automatic test_mc_reset();
    setId(1, 0, 0, 0, 0, 0, 5'd8, 1, 0, 1);
    nextCycle();
    setId(1, 5'd8, 5'd0, 1, 0, 0, 5'd10, 1, 0, 0);
    nextCycle();
    @(negedge clock);
    vectors++; if (stl !== 4'b1101) begin miscompares++; $display("FAIL mcr_busy: got %b want %b", stl, 4'b1101); end
    #1 reset = 1'b1;
    #1;
    vectors++; if ({stl, fwd, idf} !== 12'h000) begin miscompares++; $display("FAIL mcr_async: got %h want %h", {stl, fwd, idf}, 12'h000); end
    nextCycle();
    reset = 1'b0;
    idle();
    @(negedge clock);
    vectors++; if (stl !== 4'b0000) begin miscompares++; $display("FAIL mcr_after: got %b want %b", stl, 4'b0000); end
    flush();
  endtask

  // lw r5 ; mc op reading r5 : hazard stalls first, MCWAIT entered afterwards
  task automatic test_hazard_over_mc();
    setId(1, 0, 0, 0, 0, 0, 5'd5, 1, 1, 0);
    nextCycle();
    setId(1, 5'd5, 5'd0, 1, 0, 0, 5'd11, 1, 0, 1);
    @(negedge clock);
    vectors++; if (stl !== 4'b1110) begin miscompares++; $display("FAIL hmc_stall: got %b want %b", stl, 4'b1110); end
    nextCycle();
    @(negedge clock);
    vectors++; if (stl !== 4'b0000) begin miscompares++; $display("FAIL hmc_enter: got %b want %b", stl, 4'b0000); end
    nextCycle();
    idle();
    @(negedge clock);
    vectors++; if (stl !== 4'b1101) begin miscompares++; $display("FAIL hmc_busy: got %b want %b", stl, 4'b1101); end
    vectors++; if (fwd !== 4'b1000) begin miscompares++; $display("FAIL hmc_fwd: got %b want %b", fwd, 4'b1000); end
    repeat (3) nextCycle();
    @(negedge clock);
    vectors++; if (stl !== 4'b0000) begin miscompares++; $display("FAIL hmc_done: got %b want %b", stl, 4'b0000); end
    flush();
  endtask

  initial begin
    reset = 1'b0;
    idle();
    #1;
    test_reset();
    test_load_use();
    test_fwd_exmem();
    test_load_branch();
    test_back_to_back();
    test_r0_and_valid();
    test_multicycle();
    test_mc_reset();
    test_hazard_over_mc();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
